// File: rtl/ser_pkg.sv
// Shared types and constants for the bit serializer slice.
package ser_pkg;

   localparam int SER_WORD_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } ser_state_e;

   function automatic int ser_cnt_w(input int word_w);
      return $clog2(word_w + 1);
   endfunction

endpackage

// File: rtl/bit_serializer_if.sv
// Upstream word handshake plus downstream serial stream of bit_serializer.
interface bit_serializer_if
   import ser_pkg::*;
#(
   parameter int WORD_W = SER_WORD_W
);

   logic [WORD_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic              bit_out;
   logic              bit_valid;
   logic              word_done;
   logic              busy;

   modport master (
      output in_data, in_valid,
      input  in_ready, bit_out, bit_valid, word_done, busy
   );

   modport slave (
      input  in_data, in_valid,
      output in_ready, bit_out, bit_valid, word_done, busy
   );

endinterface

// File: rtl/ser_hold_buf.sv
// One-entry holding buffer with valid/ready handshake in front of the shifter.
module ser_hold_buf #(
   parameter int WORD_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WORD_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              take,
   output logic              hold_full,
   output logic [WORD_W-1:0] hold_data
);

   logic accept;

   // Accepting while the shifter drains the entry keeps the stream gap-free.
   assign in_ready = !hold_full || take;
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst)
         hold_full <= 1'b0;
      else if (accept)
         hold_full <= 1'b1;
      else if (take)
         hold_full <= 1'b0;
   end

   always_ff @(posedge clk) begin
      if (accept)
         hold_data <= in_data;
   end

endmodule

// File: rtl/bit_serializer.sv
// MSB-first word serializer with registered stream outputs.
// Define SER_PARITY_EN to append an even-parity bit after each word's LSB.
module bit_serializer
   import ser_pkg::*;
#(
   parameter int WORD_W = SER_WORD_W
) (
   input  logic             clk,
   input  logic             rst,
   bit_serializer_if.slave  bus
);

   localparam int CNT_W = ser_cnt_w(WORD_W);

   ser_state_e        state;
   logic [CNT_W-1:0]  bit_cnt;
   logic [WORD_W-1:0] shreg;
   logic              bit_out_q;
   logic              bit_valid_q;
   logic              word_done_q;
   logic              hold_full;
   logic [WORD_W-1:0] hold_data;
   logic              take;
   logic              last_bit;
`ifdef SER_PARITY_EN
   logic              par_bit;
`endif

   ser_hold_buf #(.WORD_W(WORD_W)) u_hold (
      .clk       (clk),
      .rst       (rst),
      .in_data   (bus.in_data),
      .in_valid  (bus.in_valid),
      .in_ready  (bus.in_ready),
      .take      (take),
      .hold_full (hold_full),
      .hold_data (hold_data)
   );

   assign last_bit = (bit_cnt == CNT_W'(WORD_W));

   // The hold entry moves in when the shifter is free or shows its final bit.
`ifdef SER_PARITY_EN
   assign take = hold_full && (state == IDLE || state == PARITY);
`else
   assign take = hold_full && (state == IDLE || (state == SHIFT && last_bit));
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         bit_cnt     <= '0;
         shreg       <= '0;
         bit_out_q   <= 1'b0;
         bit_valid_q <= 1'b0;
         word_done_q <= 1'b0;
      end else if (take) begin
         state       <= SHIFT;
         shreg       <= {hold_data[WORD_W-2:0], 1'b0};
         bit_out_q   <= hold_data[WORD_W-1];
         bit_valid_q <= 1'b1;
         word_done_q <= 1'b0;
         bit_cnt     <= CNT_W'(1);
`ifdef SER_PARITY_EN
         par_bit     <= ^hold_data;
`endif
      end else begin
         case (state)
            SHIFT: begin
               if (!last_bit) begin
                  bit_out_q   <= shreg[WORD_W-1];
                  shreg       <= shreg << 1;
                  bit_cnt     <= bit_cnt + CNT_W'(1);
                  bit_valid_q <= 1'b1;
`ifdef SER_PARITY_EN
                  word_done_q <= 1'b0;
`else
                  word_done_q <= (bit_cnt == CNT_W'(WORD_W - 1));
`endif
               end else begin
`ifdef SER_PARITY_EN
                  state       <= PARITY;
                  bit_out_q   <= par_bit;
                  bit_valid_q <= 1'b1;
                  word_done_q <= 1'b1;
`else
                  state       <= IDLE;
                  bit_out_q   <= 1'b0;
                  bit_valid_q <= 1'b0;
                  word_done_q <= 1'b0;
`endif
                  bit_cnt     <= '0;
               end
            end
            default: begin
               // Idle fill is all zeros so it cannot complete a 101 downstream.
               state       <= IDLE;
               bit_cnt     <= '0;
               bit_out_q   <= 1'b0;
               bit_valid_q <= 1'b0;
               word_done_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.bit_out   = bit_out_q;
   assign bus.bit_valid = bit_valid_q;
   assign bus.word_done = word_done_q;
   assign bus.busy      = hold_full || (state != IDLE);

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer; honours SER_PARITY_EN when defined.
module tb_bit_serializer;
   import ser_pkg::*;

   localparam int W = SER_WORD_W;
`ifdef SER_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int L = W + PAR;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   bit_serializer_if #(.WORD_W(W)) bus ();

   bit_serializer #(.WORD_W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int n_tests = 0;
   int n_fail  = 0;

   bit exp_bits[$];
   bit exp_done[$];

   // Downstream 101 detector: registered flag one cycle after the closing 1.
   logic [2:0] hist = 3'b000;
   logic       det  = 1'b0;
   always @(posedge clk) begin
      hist <= {hist[1:0], bus.bit_out};
      det  <= ({hist[1:0], bus.bit_out} == 3'b101);
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic void push_word(input logic [W-1:0] w);
      for (int i = W - 1; i >= 0; i--) begin
         exp_bits.push_back(w[i]);
         exp_done.push_back(i == 0 && PAR == 0);
      end
      if (PAR != 0) begin
         exp_bits.push_back(^w);
         exp_done.push_back(1'b1);
      end
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      bus.in_valid = 1'($urandom);
      bus.in_data  = W'($urandom);
      step();
      step();
      rst = 1'b0;
      bus.in_valid = 1'b0;
      n_tests++;
      if ({bus.bit_out, bus.bit_valid, bus.word_done, bus.busy, bus.in_ready} !== 5'b00001) begin
         n_fail++;
         $display("FAIL reset_outputs: got out/vld/done/busy/rdy=%b want 00001",
                  {bus.bit_out, bus.bit_valid, bus.word_done, bus.busy, bus.in_ready});
      end
   endtask

   task automatic test_single_word();
      logic [W-1:0] w;
      bit eb, ed;
      w = W'(8'hA5);
      exp_bits.delete(); exp_done.delete();
      push_word(w);
      bus.in_data  = w;
      bus.in_valid = 1'b1;
      n_tests++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL single_ready_idle: got %b want 1", bus.in_ready);
      end
      step();
      bus.in_valid = 1'b0;
      n_tests++;
      if ({bus.bit_valid, bus.busy} !== 2'b01) begin
         n_fail++; $display("FAIL single_latency_gap: got vld/busy=%b want 01", {bus.bit_valid, bus.busy});
      end
      for (int i = 0; i < L; i++) begin
         step();
         eb = exp_bits.pop_front();
         ed = exp_done.pop_front();
         n_tests++;
         if ({bus.bit_out, bus.bit_valid, bus.word_done} !== {eb, 1'b1, ed}) begin
            n_fail++;
            $display("FAIL single_bit%0d: got out/vld/done=%b want %b", i,
                     {bus.bit_out, bus.bit_valid, bus.word_done}, {eb, 1'b1, ed});
         end
      end
      step();
      n_tests++;
      if ({bus.bit_out, bus.bit_valid, bus.word_done, bus.busy} !== 4'b0000) begin
         n_fail++;
         $display("FAIL single_after: got out/vld/done/busy=%b want 0000",
                  {bus.bit_out, bus.bit_valid, bus.word_done, bus.busy});
      end
   endtask

   task automatic test_back_to_back();
      bit eb, ed;
      exp_bits.delete(); exp_done.delete();
      push_word(W'(8'hA5));
      push_word(W'(8'h3C));
      bus.in_data  = W'(8'hA5);
      bus.in_valid = 1'b1;
      step();
      bus.in_data = W'(8'h3C);
      n_tests++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL b2b_ready_load: got %b want 1", bus.in_ready);
      end
      for (int i = 0; i < 2 * L; i++) begin
         step();
         // The second word is now held; offer a decoy word that must be ignored.
         bus.in_data  = W'(8'hFF);
         bus.in_valid = (i < L - 1);
         if (i < L) begin
            n_tests++;
            if (bus.in_ready !== (i == L - 1)) begin
               n_fail++;
               $display("FAIL b2b_ready_bit%0d: got %b want %b", i, bus.in_ready, (i == L - 1));
            end
         end
         eb = exp_bits.pop_front();
         ed = exp_done.pop_front();
         n_tests++;
         if ({bus.bit_out, bus.bit_valid, bus.word_done} !== {eb, 1'b1, ed}) begin
            n_fail++;
            $display("FAIL b2b_bit%0d: got out/vld/done=%b want %b", i,
                     {bus.bit_out, bus.bit_valid, bus.word_done}, {eb, 1'b1, ed});
         end
      end
      bus.in_valid = 1'b0;
      step();
      n_tests++;
      if ({bus.bit_valid, bus.busy} !== 2'b00) begin
         n_fail++; $display("FAIL b2b_after: got vld/busy=%b want 00", {bus.bit_valid, bus.busy});
      end
   endtask

`ifdef SER_PARITY_EN
   task automatic test_parity();
      logic [8:0] expv;
      expv = 9'b0_0000_1111;
      bus.in_data  = W'(8'h07);
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      for (int i = 0; i < 9; i++) begin
         step();
         n_tests++;
         if ({bus.bit_out, bus.bit_valid, bus.word_done} !== {expv[8 - i], 1'b1, (i == 8)}) begin
            n_fail++;
            $display("FAIL parity_bit%0d: got out/vld/done=%b want %b", i,
                     {bus.bit_out, bus.bit_valid, bus.word_done}, {expv[8 - i], 1'b1, (i == 8)});
         end
      end
      step();
      n_tests++;
      if (bus.bit_valid !== 1'b0) begin
         n_fail++; $display("FAIL parity_period: got vld=%b want 0", bus.bit_valid);
      end
   endtask
`endif

   task automatic test_reset_mid_word();
      int bad;
      bus.in_data  = W'(8'hFF);
      bus.in_valid = 1'b1;
      step();
      bus.in_data = W'(8'h55);
      step();
      bus.in_valid = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         if (i > 1) step();
         n_tests++;
         if ({bus.bit_out, bus.bit_valid, bus.busy} !== 3'b111) begin
            n_fail++;
            $display("FAIL rstmid_bit%0d: got out/vld/busy=%b want 111", i, {bus.bit_out, bus.bit_valid, bus.busy});
         end
      end
      rst = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = W'(8'hAA);
      step();
      rst = 1'b0;
      bus.in_valid = 1'b0;
      n_tests++;
      if ({bus.bit_out, bus.bit_valid, bus.word_done, bus.busy, bus.in_ready} !== 5'b00001) begin
         n_fail++;
         $display("FAIL rstmid_after: got out/vld/done/busy/rdy=%b want 00001",
                  {bus.bit_out, bus.bit_valid, bus.word_done, bus.busy, bus.in_ready});
      end
      bad = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (bus.bit_valid !== 1'b0 || bus.bit_out !== 1'b0) bad++;
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++; $display("FAIL rstmid_no_bits: got %0d emitting cycles want 0", bad);
      end
      // Reset must win over a handshake offered in the same cycle.
      rst = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = W'($urandom);
      step();
      rst = 1'b0;
      bus.in_valid = 1'b0;
      bad = 0;
      for (int i = 0; i < 12; i++) begin
         if (bus.bit_valid !== 1'b0 || bus.busy !== 1'b0) bad++;
         step();
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++; $display("FAIL rst_priority: got %0d busy/emitting cycles want 0", bad);
      end
   endtask

   task automatic test_detector();
      int det_cnt, det_at;
      for (int i = 0; i < 5; i++) step();
      bus.in_data  = W'(8'h05);
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      det_cnt = 0;
      det_at  = -1;
      for (int s = 1; s <= L + 5; s++) begin
         step();
         if (det === 1'b1) begin
            det_cnt++;
            if (det_at < 0) det_at = s;
         end
      end
      n_tests++;
      if (det_cnt != 1 || det_at != W + 1) begin
         n_fail++;
         $display("FAIL detect_word05: got %0d detections at %0d want 1 at %0d", det_cnt, det_at, W + 1);
      end
      det_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (det !== 1'b0) det_cnt++;
      end
      n_tests++;
      if (det_cnt != 0) begin
         n_fail++; $display("FAIL detect_idle: got %0d detections want 0", det_cnt);
      end
   endtask

   task automatic test_random();
      int  accepted, cycles, bad;
      bit  acc, prev_vld, prev_done, eb, ed;
      logic [W-1:0] w;
      exp_bits.delete(); exp_done.delete();
      accepted = 0; cycles = 0; bad = 0;
      prev_vld = 1'b0; prev_done = 1'b0;
      while ((accepted < 30 || exp_bits.size() != 0) && cycles < 3000) begin
         w = W'($urandom);
         bus.in_data  = w;
         bus.in_valid = (accepted < 30) && ($urandom_range(0, 3) != 0);
         acc = bus.in_valid && bus.in_ready;
         step();
         cycles++;
         if (acc) begin
            push_word(w);
            accepted++;
         end
         n_tests++;
         if (bus.busy !== (exp_bits.size() != 0)) begin
            n_fail++;
            $display("FAIL rand_busy_c%0d: got %b want %b", cycles, bus.busy, (exp_bits.size() != 0));
         end
         if (bus.bit_valid === 1'b1) begin
            if (exp_bits.size() == 0) begin
               bad++;
               $display("FAIL rand_extra_bit_c%0d: got valid bit want none", cycles);
            end else begin
               eb = exp_bits.pop_front();
               ed = exp_done.pop_front();
               n_tests++;
               if ({bus.bit_out, bus.word_done} !== {eb, ed}) begin
                  n_fail++;
                  $display("FAIL rand_bit_c%0d: got out/done=%b want %b", cycles,
                           {bus.bit_out, bus.word_done}, {eb, ed});
               end
            end
         end else begin
            n_tests++;
            if ({bus.bit_out, bus.word_done} !== 2'b00 || (prev_vld && !prev_done)) begin
               n_fail++;
               $display("FAIL rand_idle_c%0d: got out/done=%b gap=%b want 00 no gap", cycles,
                        {bus.bit_out, bus.word_done}, (prev_vld && !prev_done));
            end
         end
         prev_vld  = bus.bit_valid;
         prev_done = bus.word_done;
      end
      bus.in_valid = 1'b0;
      n_tests++;
      if (bad != 0 || exp_bits.size() != 0 || accepted != 30) begin
         n_fail++;
         $display("FAIL rand_drain: got extra=%0d left=%0d words=%0d want 0 0 30",
                  bad, exp_bits.size(), accepted);
      end
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      test_reset();
      test_single_word();
      test_back_to_back();
`ifdef SER_PARITY_EN
      test_parity();
`endif
      test_reset_mid_word();
      test_detector();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 SHALL have parameter WORD_W, default 8, meaning parallel word width (legal range 2..32).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port in_data, input, WORD_W bits: parallel word to serialize.
REQ-005 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: block can accept a word this cycle.
REQ-007 SHALL have port bit_out, output, 1 bit: serial stream for the downstream "101" sequence detector's data input.
REQ-008 SHALL have port bit_valid, output, 1 bit: bit_out carries a data or parity bit.
REQ-009 SHALL have port word_done, output, 1 bit: pulse while the last bit of a word is presented.
REQ-010 SHALL have port busy, output, 1 bit: holding buffer or shifter occupied.

Function
REQ-011 SHALL accept a word on any rising edge where in_valid and in_ready are both 1; in_data SHALL be captured into a one-entry holding buffer.
REQ-012 SHALL drive in_ready = !hold_full OR shifter loading from hold this cycle, giving gap-free streaming.
REQ-013 SHALL move the hold contents into the shifter on the edge where the shifter is in IDLE, or is presenting the final bit of its current word.
REQ-014 SHALL emit bits MSB-first, one per cycle; bit_out and bit_valid SHALL be registered.
REQ-015 SHALL, for a word accepted at edge k with the shifter idle, present its MSB during the cycle after edge k+1: a latency of 2 cycles.
REQ-016 SHALL implement states IDLE, SHIFT and PARITY:
- IDLE->SHIFT on hold load.
- SHIFT stays in SHIFT for WORD_W cycles, counted by a bit counter of width clog2(WORD_W+1).
- After the last data bit, SHIFT->PARITY if parity is enabled.
- Otherwise SHIFT->SHIFT if hold is full, or SHIFT->IDLE.
- PARITY->SHIFT if hold is full, else PARITY->IDLE.
REQ-017 SHALL drive bit_out=0 and bit_valid=0 in IDLE, so that idle fill can never form a false 101 pattern.
REQ-018 SHALL assert word_done for exactly one cycle, coincident with the final bit of each word (the LSB, or the parity bit when enabled).
REQ-019 SHALL assert busy when hold_full=1 or state!=IDLE.
REQ-020 SHALL ignore in_data while in_ready=0; the captured word SHALL not change until it is transferred.
REQ-021 SHALL sustain back-to-back words with no idle cycle, at a rate of one word per WORD_W cycles (WORD_W+1 cycles with parity).

Reset
REQ-022 SHALL, on rst=1 at a rising edge, set state=IDLE, hold_full=0, bit counter=0 and shift register=0.
REQ-023 SHALL drive bit_out=0, bit_valid=0, word_done=0 and busy=0 in the cycle after reset; in_ready SHALL be 1 in that cycle.
REQ-024 SHALL, on reset mid-word, discard the in-flight word and the held word with no further bits emitted; rst SHALL take priority over a simultaneous handshake.

Configuration
REQ-025 SHALL, with macro SER_PARITY_EN defined, append one even-parity bit (XOR of all word bits) after the LSB, with bit_valid=1 during that bit.
REQ-026 SHALL, without SER_PARITY_EN, omit the PARITY state and its logic entirely; the word period SHALL be WORD_W cycles.

Structure
REQ-027 SHALL take from shared package ser_pkg:
- the state enum type (IDLE/SHIFT/PARITY);
- the default word width constant SER_WORD_W=8.
REQ-028 SHALL instantiate one sub-module, ser_hold_buf, the one-entry holding buffer with valid/ready handshake; the shifter and FSM SHALL live in bit_serializer.

Verification
REQ-029 SHALL cover: single word 8'hA5 accepted at edge 0 -> bit_out 1,0,1,0,0,1,0,1 in cycles 2..9; word_done in cycle 9; bit_valid=0 from cycle 10.
REQ-030 SHALL cover: back-to-back 8'hA5 then 8'h3C with in_valid held -> 16 contiguous valid bits ending 0,0,1,1,1,1,0,0; in_ready low while hold_full and no transfer occurs.
REQ-031 SHALL cover: SER_PARITY_EN defined, word 8'h07 -> 8 data bits then parity bit 1; 9-cycle period; word_done on the parity bit.
REQ-032 SHALL cover: rst asserted in the 4th bit cycle of 8'hFF with hold holding 8'h55 -> next cycle bit_out=0, bit_valid=0, busy=0, in_ready=1; no 8'h55 bits are ever emitted.
REQ-033 SHALL cover: word 8'b0000_0101 driving the downstream 101 detector -> exactly one detection, one cycle after the final 1; an idle stream for 20 cycles -> no detection.
